// File: rtl/tl_buffer_pkg.sv
// Shared widths, legal queue depths and packed payload types for the TileLink A/D buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tl_buffer_pkg;

  // A channel field widths
  localparam int A_OPCODE_W = 3;
  localparam int A_PARAM_W  = 3;
  localparam int A_SIZE_W   = 4;
  localparam int A_SOURCE_W = 5;
  localparam int A_ADDR_W   = 28;
  localparam int A_MASK_W   = 8;
  localparam int A_DATA_W   = 64;

  // D channel field widths
  localparam int D_OPCODE_W = 3;
  localparam int D_PARAM_W  = 2;
  localparam int D_SIZE_W   = 4;
  localparam int D_SOURCE_W = 5;
  localparam int D_SINK_W   = 1;
  localparam int D_DATA_W   = 64;

  // Queue depths the pointer/count logic is built for (powers of two only)
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 4;

  function automatic bit depth_legal(input int d);
    return (d == DEPTH_MIN) || (d == DEPTH_MAX);
  endfunction

  typedef struct packed {
    logic [A_OPCODE_W-1:0] opcode;
    logic [A_PARAM_W-1:0]  param;
    logic [A_SIZE_W-1:0]   size;
    logic [A_SOURCE_W-1:0] source;
    logic [A_ADDR_W-1:0]   address;
    logic [A_MASK_W-1:0]   mask;
    logic [A_DATA_W-1:0]   data;
    logic                  corrupt;
  } a_bits_t;

  typedef struct packed {
    logic [D_OPCODE_W-1:0] opcode;
    logic [D_PARAM_W-1:0]  param;
    logic [D_SIZE_W-1:0]   size;
    logic [D_SOURCE_W-1:0] source;
    logic [D_SINK_W-1:0]   sink;
    logic                  denied;
    logic [D_DATA_W-1:0]   data;
    logic                  corrupt;
  } d_bits_t;

endpackage

// File: rtl/tl_buffer_2_if.sv
// Bundle of the upstream (auto_in_*) and crossbar-side (auto_out_*) A/D channels.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; slave modport is the buffer's view.
interface tl_buffer_2_if;
  import tl_buffer_pkg::*;

  // upstream A (into the buffer)
  logic                  auto_in_a_valid;
  logic                  auto_in_a_ready;
  logic [A_OPCODE_W-1:0] auto_in_a_bits_opcode;
  logic [A_PARAM_W-1:0]  auto_in_a_bits_param;
  logic [A_SIZE_W-1:0]   auto_in_a_bits_size;
  logic [A_SOURCE_W-1:0] auto_in_a_bits_source;
  logic [A_ADDR_W-1:0]   auto_in_a_bits_address;
  logic [A_MASK_W-1:0]   auto_in_a_bits_mask;
  logic [A_DATA_W-1:0]   auto_in_a_bits_data;
  logic                  auto_in_a_bits_corrupt;

  // crossbar A (out of the buffer)
  logic                  auto_out_a_valid;
  logic                  auto_out_a_ready;
  logic [A_OPCODE_W-1:0] auto_out_a_bits_opcode;
  logic [A_PARAM_W-1:0]  auto_out_a_bits_param;
  logic [A_SIZE_W-1:0]   auto_out_a_bits_size;
  logic [A_SOURCE_W-1:0] auto_out_a_bits_source;
  logic [A_ADDR_W-1:0]   auto_out_a_bits_address;
  logic [A_MASK_W-1:0]   auto_out_a_bits_mask;
  logic [A_DATA_W-1:0]   auto_out_a_bits_data;
  logic                  auto_out_a_bits_corrupt;

  // crossbar D (into the buffer)
  logic                  auto_out_d_valid;
  logic                  auto_out_d_ready;
  logic [D_OPCODE_W-1:0] auto_out_d_bits_opcode;
  logic [D_PARAM_W-1:0]  auto_out_d_bits_param;
  logic [D_SIZE_W-1:0]   auto_out_d_bits_size;
  logic [D_SOURCE_W-1:0] auto_out_d_bits_source;
  logic [D_SINK_W-1:0]   auto_out_d_bits_sink;
  logic                  auto_out_d_bits_denied;
  logic [D_DATA_W-1:0]   auto_out_d_bits_data;
  logic                  auto_out_d_bits_corrupt;

  // upstream D (out of the buffer)
  logic                  auto_in_d_valid;
  logic                  auto_in_d_ready;
  logic [D_OPCODE_W-1:0] auto_in_d_bits_opcode;
  logic [D_PARAM_W-1:0]  auto_in_d_bits_param;
  logic [D_SIZE_W-1:0]   auto_in_d_bits_size;
  logic [D_SOURCE_W-1:0] auto_in_d_bits_source;
  logic [D_SINK_W-1:0]   auto_in_d_bits_sink;
  logic                  auto_in_d_bits_denied;
  logic [D_DATA_W-1:0]   auto_in_d_bits_data;
  logic                  auto_in_d_bits_corrupt;

  // the buffer itself
  modport slave (
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt,
    output auto_in_a_ready,
    output auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt,
    input  auto_out_a_ready,
    input  auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
           auto_out_d_bits_data, auto_out_d_bits_corrupt,
    output auto_out_d_ready,
    output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
           auto_in_d_bits_data, auto_in_d_bits_corrupt,
    input  auto_in_d_ready
  );

  // the environment around the buffer (upstream agent + crossbar)
  modport master (
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt,
    input  auto_in_a_ready,
    input  auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt,
    output auto_out_a_ready,
    output auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
           auto_out_d_bits_data, auto_out_d_bits_corrupt,
    input  auto_out_d_ready,
    input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
           auto_in_d_bits_data, auto_in_d_bits_corrupt,
    output auto_in_d_ready
  );

endinterface

// File: rtl/tl_buffer_queue.sv
// Order-preserving DEPTH-entry queue of W-bit beats; optional flow-through via TL_BUFFER_FLOW_EN.
// Latency: 1 cycle enqueue->dequeue valid; 0 cycles when empty with TL_BUFFER_FLOW_EN.
// Backpressure: enq_ready = not full from registered count only; full refuses even on a same-cycle dequeue.
module tl_buffer_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enq_valid,
  output logic         enq_ready,
  input  logic [W-1:0] enq_bits,
  output logic         deq_valid,
  input  logic         deq_ready,
  output logic [W-1:0] deq_bits
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL    = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [W-1:0] mem [DEPTH];
  ptr_t         wr_ptr;
  ptr_t         rd_ptr;
  cnt_t         count;

  logic empty;
  logic do_enq;
  logic do_deq;
  logic wr_en;
  logic rd_en;

  assign empty     = (count == '0);
  assign enq_ready = (count != FULL);
  assign do_enq    = enq_valid & enq_ready;

`ifdef TL_BUFFER_FLOW_EN
  // Empty queue passes the incoming beat straight through; it is only
  // written to storage when the consumer does not take it this cycle.
  assign deq_valid = ~empty | enq_valid;
  assign deq_bits  = empty ? enq_bits : mem[rd_ptr];
  assign do_deq    = deq_valid & deq_ready;
  assign wr_en     = do_enq & ~(empty & do_deq);
  assign rd_en     = do_deq & ~empty;
`else
  assign deq_valid = ~empty;
  assign deq_bits  = mem[rd_ptr];
  assign do_deq    = deq_valid & deq_ready;
  assign wr_en     = do_enq;
  assign rd_en     = do_deq;
`endif

  // Occupancy and wrapping pointers; reset drops every queued beat at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Beat storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= enq_bits;
  end

endmodule

// File: rtl/tl_buffer_2.sv
// TileLink buffer: one independent queue on A (in->out) and one on D (out->in). Option macro: TL_BUFFER_FLOW_EN.
// Latency: 1 cycle per channel; 0 cycles through an empty queue when TL_BUFFER_FLOW_EN is defined.
// Backpressure: each enqueue ready is "queue not full", independent of the downstream ready.
module tl_buffer_2
  import tl_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  tl_buffer_2_if.slave bus
);

  // Pointer arithmetic relies on a power-of-two depth.
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("tl_buffer_2: DEPTH must be 2 or 4");
  end

  a_bits_t a_in;
  a_bits_t a_out;
  d_bits_t d_in;
  d_bits_t d_out;

  assign a_in = '{
    opcode:  bus.auto_in_a_bits_opcode,
    param:   bus.auto_in_a_bits_param,
    size:    bus.auto_in_a_bits_size,
    source:  bus.auto_in_a_bits_source,
    address: bus.auto_in_a_bits_address,
    mask:    bus.auto_in_a_bits_mask,
    data:    bus.auto_in_a_bits_data,
    corrupt: bus.auto_in_a_bits_corrupt
  };

  assign d_in = '{
    opcode:  bus.auto_out_d_bits_opcode,
    param:   bus.auto_out_d_bits_param,
    size:    bus.auto_out_d_bits_size,
    source:  bus.auto_out_d_bits_source,
    sink:    bus.auto_out_d_bits_sink,
    denied:  bus.auto_out_d_bits_denied,
    data:    bus.auto_out_d_bits_data,
    corrupt: bus.auto_out_d_bits_corrupt
  };

  tl_buffer_queue #(.W($bits(a_bits_t)), .DEPTH(DEPTH)) u_a_q (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (bus.auto_in_a_valid),
    .enq_ready (bus.auto_in_a_ready),
    .enq_bits  (a_in),
    .deq_valid (bus.auto_out_a_valid),
    .deq_ready (bus.auto_out_a_ready),
    .deq_bits  (a_out)
  );

  tl_buffer_queue #(.W($bits(d_bits_t)), .DEPTH(DEPTH)) u_d_q (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (bus.auto_out_d_valid),
    .enq_ready (bus.auto_out_d_ready),
    .enq_bits  (d_in),
    .deq_valid (bus.auto_in_d_valid),
    .deq_ready (bus.auto_in_d_ready),
    .deq_bits  (d_out)
  );

  assign bus.auto_out_a_bits_opcode  = a_out.opcode;
  assign bus.auto_out_a_bits_param   = a_out.param;
  assign bus.auto_out_a_bits_size    = a_out.size;
  assign bus.auto_out_a_bits_source  = a_out.source;
  assign bus.auto_out_a_bits_address = a_out.address;
  assign bus.auto_out_a_bits_mask    = a_out.mask;
  assign bus.auto_out_a_bits_data    = a_out.data;
  assign bus.auto_out_a_bits_corrupt = a_out.corrupt;

  assign bus.auto_in_d_bits_opcode   = d_out.opcode;
  assign bus.auto_in_d_bits_param    = d_out.param;
  assign bus.auto_in_d_bits_size     = d_out.size;
  assign bus.auto_in_d_bits_source   = d_out.source;
  assign bus.auto_in_d_bits_sink     = d_out.sink;
  assign bus.auto_in_d_bits_denied   = d_out.denied;
  assign bus.auto_in_d_bits_data     = d_out.data;
  assign bus.auto_in_d_bits_corrupt  = d_out.corrupt;

endmodule
